// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 message front end.
//   WORD_W / BLK_W / LEN_W / DIG_W : datapath widths
//   H_0                            : initial chaining value
//   state_e                        : front-end control states
package sha256_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 512;
  localparam int unsigned LEN_W  = 64;
  localparam int unsigned DIG_W  = 256;

  localparam logic [DIG_W-1:0] H_0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] PAD_MARK = 32'h8000_0000;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    HASH   = 2'd2,
    OUT    = 2'd3
  } state_e;

endpackage

// File: rtl/sha256_stream_master_if.sv
// Signal bundle of the SHA-256 message front end.
//   in_*      : message word stream (valid/ready)
//   blk_*     : block-processor handshake (front end is the master)
//   digest*   : final digest output (valid/ready)
// Modport master is the front end's view; slave is the surrounding environment.
interface sha256_stream_master_if;
  import sha256_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic [2:0]        in_bytes;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;

  logic [DIG_W-1:0]  blk_H;
  logic [BLK_W-1:0]  blk_M;
  logic              blk_start;
  logic [DIG_W-1:0]  blk_H_out;
  logic              blk_done;

  logic [DIG_W-1:0]  digest;
  logic              digest_valid;
  logic              digest_ready;

  modport master (
    input  in_data, in_bytes, in_last, in_valid,
    output in_ready,
    output blk_H, blk_M, blk_start,
    input  blk_H_out, blk_done,
    output digest, digest_valid,
    input  digest_ready
  );

  modport slave (
    output in_data, in_bytes, in_last, in_valid,
    input  in_ready,
    input  blk_H, blk_M, blk_start,
    output blk_H_out, blk_done,
    input  digest, digest_valid,
    output digest_ready
  );

endinterface

// File: rtl/sha256_pad_word.sv
// Combinational message-word merge.
//   data_i  : incoming word, first byte in [31:24]
//   bytes_i : number of valid left-aligned bytes (0..4)
//   last_i  : word is the final one of the message
//   word_o  : word with invalid bytes zeroed and, on a short last word,
//             0x80 placed in the first byte after the message
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [2:0]        bytes_i,
  input  logic              last_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < {29'd0, bytes_i}) begin
        word_o[31-8*k -: 8] = data_i[31-8*k -: 8];
      end else if (last_i && (k == {29'd0, bytes_i})) begin
        word_o[31-8*k -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha256_stream_master.sv
// SHA-256 message front end: pads the incoming word stream, appends the
// 64-bit bit length, and feeds 512-bit blocks with chained hash to an
// external block processor; presents the final digest via valid/ready.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sha256_stream_master_if.master (stream in, block port, digest out)
module sha256_stream_master
  import sha256_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  sha256_stream_master_if.master bus
);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               pad_after_q, pad_after_d;
  logic               final_q, final_d;
  logic               pend_q, pend_d;      // length-only block still owed
  logic               lenw_q, lenw_d;      // word 14 of this block holds len hi
  logic               start_q, start_d;
  logic [DIG_W-1:0]   h_q, h_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic [WORD_W-1:0]  buf_q [16];
  logic               wr_en;
  logic [WORD_W-1:0]  wr_data;
  logic [WORD_W-1:0]  pad_word;
  logic [BLK_W-1:0]   blk_m;

  sha256_pad_word u_pad (
    .data_i  (bus.in_data),
    .bytes_i (bus.in_bytes),
    .last_i  (bus.in_last),
    .word_o  (pad_word)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    pad_after_d = pad_after_q;
    final_d     = final_q;
    pend_d      = pend_q;
    lenw_d      = lenw_q;
    start_d     = 1'b0;
    h_d         = h_q;
    dig_d       = dig_q;
    wr_en       = 1'b0;
    wr_data     = pad_word;

    unique case (state_q)
      ACCEPT: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          len_d = len_q + {58'd0, bus.in_bytes, 3'b000};
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            // Block is full even if this was the last word: hash it first,
            // padding/length continue in a fresh block afterwards.
            state_d     = HASH;
            start_d     = 1'b1;
            final_d     = 1'b0;
            pend_d      = bus.in_last;
            pad_after_d = bus.in_last && (bus.in_bytes == 3'd4);
          end else if (bus.in_last) begin
            state_d     = PAD;
            pad_after_d = (bus.in_bytes == 3'd4);
          end
        end
      end

      PAD: begin
        wr_en = 1'b1;
        idx_d = idx_q + 4'd1;
        if (pad_after_q) begin
          wr_data     = PAD_MARK;
          pad_after_d = 1'b0;
        end else if (idx_q == 4'd14) begin
          wr_data = len_q[63:32];
          lenw_d  = 1'b1;
        end else if ((idx_q == 4'd15) && lenw_q) begin
          wr_data = len_q[31:0];
        end else begin
          wr_data = '0;
        end
        if (idx_q == 4'd15) begin
          // Length only fits when word 14 took len hi; otherwise this block
          // just closes and a length-only block follows.
          state_d = HASH;
          start_d = 1'b1;
          lenw_d  = 1'b0;
          final_d = lenw_q;
          pend_d  = !lenw_q;
        end
      end

      HASH: begin
        // A done in the start cycle belongs to no block of ours.
        if (bus.blk_done && !start_q) begin
          h_d   = bus.blk_H_out;
          idx_d = '0;
          if (final_q) begin
            dig_d   = bus.blk_H_out;
            final_d = 1'b0;
            state_d = OUT;
          end else if (pend_q) begin
            pend_d  = 1'b0;
            state_d = PAD;
          end else begin
            state_d = ACCEPT;
          end
        end
      end

      OUT: begin
        if (bus.digest_ready) begin
          state_d = ACCEPT;
          h_d     = H_0;
          len_d   = '0;
        end
      end

      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCEPT;
      idx_q       <= '0;
      len_q       <= '0;
      pad_after_q <= 1'b0;
      final_q     <= 1'b0;
      pend_q      <= 1'b0;
      lenw_q      <= 1'b0;
      start_q     <= 1'b0;
      h_q         <= H_0;
      dig_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      pad_after_q <= pad_after_d;
      final_q     <= final_d;
      pend_q      <= pend_d;
      lenw_q      <= lenw_d;
      start_q     <= start_d;
      h_q         <= h_d;
      dig_q       <= dig_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) begin
        buf_q[i] <= '0;
      end
    end else if (wr_en) begin
      buf_q[idx_q] <= wr_data;
    end
  end

  always_comb begin
    blk_m = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      blk_m[BLK_W-1-32*i -: 32] = buf_q[i];
    end
  end

  assign bus.in_ready     = (state_q == ACCEPT);
  assign bus.digest_valid = (state_q == OUT);
  assign bus.blk_start    = start_q;
  assign bus.blk_H        = h_q;
  assign bus.blk_M        = blk_m;
  assign bus.digest       = dig_q;

endmodule

// File: tb/tb_sha256_stream_master.sv
// Directed bench for sha256_stream_master: a behavioural block processor
// answers blk_start, an independent padding/compression reference yields
// the expected blocks and digests, and known FIPS digests are checked.
module tb_sha256_stream_master;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_stream_master_if bus ();

  sha256_stream_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [255:0] DIG_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_56 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Block-processor model and monitors
  logic         model_done = 1'b0;
  logic         stray_done = 1'b0;
  logic         abort = 1'b0;
  logic [255:0] model_hout = '0;
  assign bus.blk_done  = model_done | stray_done;
  assign bus.blk_H_out = model_hout;

  logic [511:0]  cap_q [$];
  int unsigned   n_start = 0;
  int unsigned   start_cycles = 0;
  int unsigned   stab_err = 0;

  initial begin : proc_model
    logic [255:0] ch;
    logic [511:0] cm;
    logic [255:0] res;
    forever begin
      @(posedge clk); #1;
      if (bus.blk_start) begin
        ch = bus.blk_H;
        cm = bus.blk_M;
        cap_q.push_back(cm);
        n_start++;
        res = compress(ch, cm);
        repeat (3) begin
          @(posedge clk); #1;
          if (!abort && ((bus.blk_M !== cm) || (bus.blk_H !== ch))) stab_err++;
        end
        model_hout = res;
        model_done = 1'b1;
        @(posedge clk); #1;
        model_done = 1'b0;
      end
    end
  end

  initial begin : proc_start_mon
    forever begin
      @(posedge clk); #1;
      if (bus.blk_start) start_cycles++;
    end
  end

  initial begin : proc_watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference padding
  byte unsigned  msg_q [$];
  logic [511:0]  exp_q [$];
  logic [255:0]  exp_dig;

  task automatic build_ref();
    byte unsigned p [$];
    logic [63:0]  bl;
    logic [511:0] blk;
    logic [255:0] hv;
    p  = msg_q;
    bl = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    exp_q.delete();
    hv = H_0;
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      exp_q.push_back(blk);
      hv = compress(hv, blk);
    end
    exp_dig = hv;
  endtask

  task automatic send_msg(input bit stall);
    int n, nw, nb, bi;
    logic [31:0] d;
    bit ok;
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      if (stall) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      nb = (w == nw - 1) ? n - 4 * w : 4;
      for (int b = 0; b < 4; b++) begin
        bi = 4 * w + b;
        d[31-8*b -: 8] = (bi < n) ? msg_q[bi] : 8'h5A;
      end
      bus.in_data  = d;
      bus.in_bytes = 3'(nb);
      bus.in_last  = (w == nw - 1);
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        if (bus.in_ready) ok = 1'b1;
        @(posedge clk); #1;
      end
      if (!ok) begin
        chk("accept_timeout", 512'(ok), 512'(1));
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_msg(input string tag, input bit stall, input int hold,
                         input logic [255:0] spec_dig, input bit has_spec);
    bit ok;
    cap_q.delete();
    n_start = 0;
    start_cycles = 0;
    stab_err = 0;
    build_ref();
    send_msg(stall);
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      if (bus.digest_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) chk({tag, "_digest_timeout"}, 512'(ok), 512'(1));
    chk({tag, "_digest"}, 512'(bus.digest), 512'(exp_dig));
    if (has_spec) chk({tag, "_known_digest"}, 512'(bus.digest), 512'(spec_dig));
    chk({tag, "_nstart"}, 512'(n_start), 512'(exp_q.size()));
    chk({tag, "_start_cycles"}, 512'(start_cycles), 512'(exp_q.size()));
    chk({tag, "_stable"}, 512'(stab_err), 512'(0));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("%s_blk%0d", tag, i), cap_q[i], exp_q[i]);
    for (int hc = 0; hc < hold; hc++) begin
      bus.digest_ready = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_bp_valid"}, 512'(bus.digest_valid), 512'(1));
      chk({tag, "_bp_digest"}, 512'(bus.digest), 512'(exp_dig));
      chk({tag, "_bp_in_ready"}, 512'(bus.in_ready), 512'(0));
    end
    bus.digest_ready = 1'b1;
    @(posedge clk); #1;
    bus.digest_ready = 1'b0;
    chk({tag, "_post_valid"}, 512'(bus.digest_valid), 512'(0));
    chk({tag, "_post_in_ready"}, 512'(bus.in_ready), 512'(1));
    chk({tag, "_post_H"}, 512'(bus.blk_H), 512'(H_0));
  endtask

  initial begin : proc_main
    bit ok;
    bus.in_data      = '0;
    bus.in_bytes     = '0;
    bus.in_last      = 1'b0;
    bus.in_valid     = 1'b0;
    bus.digest_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 512'(bus.in_ready), 512'(1));
    chk("rst_blk_start", 512'(bus.blk_start), 512'(0));
    chk("rst_digest_valid", 512'(bus.digest_valid), 512'(0));
    chk("rst_digest", 512'(bus.digest), 512'(0));
    chk("rst_blk_M", bus.blk_M, 512'(0));
    chk("rst_blk_H", 512'(bus.blk_H), 512'(H_0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc" with output backpressure, then again from a fresh H_0
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", 1'b0, 5, DIG_ABC, 1'b1);
    run_msg("abc2", 1'b0, 0, DIG_ABC, 1'b1);

    // Stray done while idle in ACCEPT
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    @(posedge clk); #1;
    chk("stray_in_ready", 512'(bus.in_ready), 512'(1));
    chk("stray_blk_H", 512'(bus.blk_H), 512'(H_0));
    chk("stray_digest_valid", 512'(bus.digest_valid), 512'(0));
    chk("stray_blk_start", 512'(bus.blk_start), 512'(0));

    // Empty message
    msg_q.delete();
    run_msg("empty", 1'b0, 0, DIG_EMPTY, 1'b1);
    if (cap_q.size() > 0) begin
      chk("empty_word0", 512'(cap_q[0][511:480]), 512'(32'h8000_0000));
      chk("empty_word14_15", 512'(cap_q[0][63:0]), 512'(0));
    end

    // 56-byte message: length spills into a second block
    msg_q.delete();
    for (int i = 0; i < 56; i++) msg_q.push_back(8'(8'h61 + i / 4 + i % 4));
    run_msg("abcdbc56", 1'b0, 0, DIG_56, 1'b1);
    if (cap_q.size() > 1) begin
      chk("abcdbc56_blk1_word15", 512'(cap_q[1][31:0]), 512'(32'h0000_01c0));
      chk("abcdbc56_blk1_word14", 512'(cap_q[1][63:32]), 512'(0));
    end

    // Marker lands in word 14, then in word 15
    msg_q.delete();
    for (int i = 0; i < 59; i++) msg_q.push_back(8'(i * 3 + 1));
    run_msg("len59", 1'b0, 0, '0, 1'b0);
    msg_q.delete();
    for (int i = 0; i < 63; i++) msg_q.push_back(8'(i * 5 + 2));
    run_msg("len63", 1'b0, 0, '0, 1'b0);

    // 128-byte message, gap-free then with random input stalls
    msg_q.delete();
    for (int i = 0; i < 128; i++) msg_q.push_back(8'(i * 7 + 3));
    run_msg("len128", 1'b0, 0, '0, 1'b0);
    run_msg("len128_stall", 1'b1, 0, '0, 1'b0);

    // Reset asserted during HASH
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (bus.blk_start) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) chk("hash_reach_timeout", 512'(ok), 512'(1));
    #2;
    abort = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 512'(bus.in_ready), 512'(1));
    chk("arst_blk_start", 512'(bus.blk_start), 512'(0));
    chk("arst_blk_H", 512'(bus.blk_H), 512'(H_0));
    chk("arst_blk_M", bus.blk_M, 512'(0));
    chk("arst_digest_valid", 512'(bus.digest_valid), 512'(0));
    chk("arst_digest", 512'(bus.digest), 512'(0));
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("late_done_in_ready", 512'(bus.in_ready), 512'(1));
    chk("late_done_valid", 512'(bus.digest_valid), 512'(0));
    chk("late_done_blk_H", 512'(bus.blk_H), 512'(H_0));
    chk("late_done_blk_M", bus.blk_M, 512'(0));
    abort = 1'b0;

    run_msg("abc_after_rst", 1'b0, 0, DIG_ABC, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
